// File: rtl/dmem_miss_ctrl_if.sv
// Memory-side bus between the miss controller (master) and the data memory (slave).
interface dmem_miss_ctrl_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BLOCK_W = 128
);
  logic               mem_ren;
  logic               mem_wen;
  logic [ADDR_W-1:0]  mem_block_address;
  logic [BLOCK_W-1:0] mem_din;
  logic               mem_ready;
  logic               mem_done;
  logic [BLOCK_W-1:0] mem_dout;

  modport master (
    output mem_ren,
    output mem_wen,
    output mem_block_address,
    output mem_din,
    input  mem_ready,
    input  mem_done,
    input  mem_dout
  );

  modport slave (
    input  mem_ren,
    input  mem_wen,
    input  mem_block_address,
    input  mem_din,
    output mem_ready,
    output mem_done,
    output mem_dout
  );
endinterface

// File: rtl/dmem_miss_ctrl.sv
// Data-cache miss handler: optional dirty write-back, one-cycle gap, block fetch,
// one-cycle fill response, plus a per-operation watchdog that parks in an error state.
module dmem_miss_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               miss_req,
  input  logic               victim_dirty,
  input  logic [ADDR_W-1:0]  victim_addr,
  input  logic [BLOCK_W-1:0] victim_data,
  input  logic [ADDR_W-1:0]  fill_addr,
  output logic               busy,
  output logic               fill_valid,
  output logic [BLOCK_W-1:0] fill_data,
  output logic               err,
  dmem_miss_ctrl_if.master   mem
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StGap,
    StFill,
    StResp,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]  victim_addr_q, victim_addr_d;
  logic [BLOCK_W-1:0] victim_data_q, victim_data_d;
  logic [ADDR_W-1:0]  fill_addr_q, fill_addr_d;
  logic [BLOCK_W-1:0] fill_data_q, fill_data_d;

  // Next-state, request latching, watchdog and fill capture.
  always_comb begin
    state_d       = state_q;
    victim_addr_d = victim_addr_q;
    victim_data_d = victim_data_q;
    fill_addr_d   = fill_addr_q;
    fill_data_d   = fill_data_q;
    unique case (state_q)
      StIdle: begin
        if (miss_req) begin
          victim_addr_d = victim_addr;
          victim_data_d = victim_data;
          fill_addr_d   = fill_addr;
          state_d       = victim_dirty ? StWb : StFill;
        end
      end
      StWb: begin
        if (mem.mem_done) begin
          state_d = StGap;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end
      end
      StGap: state_d = StFill;
      StFill: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (mem.mem_ready) begin
          fill_data_d = mem.mem_dout;
          state_d     = StResp;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end
      end
      StResp: state_d = StIdle;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase

    // Every entry into WB/FILL is a state change, so clearing on any change suffices.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StWb || state_q == StFill) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Outputs decoded purely from the state register and latched request.
  always_comb begin
    busy                  = (state_q != StIdle);
    fill_valid            = (state_q == StResp);
    err                   = (state_q == StErr);
    fill_data             = fill_data_q;
    mem.mem_ren           = (state_q == StFill);
    mem.mem_wen           = (state_q == StWb);
    mem.mem_block_address = '0;
    mem.mem_din           = '0;
    unique case (state_q)
      StWb: begin
        mem.mem_block_address = victim_addr_q;
        mem.mem_din           = victim_data_q;
      end
      StGap, StFill: mem.mem_block_address = fill_addr_q;
      default: mem.mem_block_address = '0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      fill_addr_q   <= '0;
      fill_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      victim_addr_q <= victim_addr_d;
      victim_data_q <= victim_data_d;
      fill_addr_q   <= fill_addr_d;
      fill_data_q   <= fill_data_d;
    end
  end

endmodule

// File: tb/tb_dmem_miss_ctrl.sv
// Directed bench for dmem_miss_ctrl with a small delay-programmable memory model.
module tb_dmem_miss_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          miss_req = 1'b0;
  logic          victim_dirty = 1'b0;
  logic [AW-1:0] victim_addr = '0;
  logic [BW-1:0] victim_data = '0;
  logic [AW-1:0] fill_addr = '0;
  logic          busy, fill_valid, err;
  logic [BW-1:0] fill_data;

  int errors = 0;
  int checks = 0;

  localparam logic [BW-1:0] DataBeef = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [BW-1:0] DataA5   = {16{8'hA5}};
  localparam logic [BW-1:0] Data5A   = {16{8'h5A}};
  localparam logic [BW-1:0] Data41   = 128'h4141_0000_1111_2222_3333_4444_5555_4141;

  dmem_miss_ctrl_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

  dmem_miss_ctrl #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .miss_req     (miss_req),
    .victim_dirty (victim_dirty),
    .victim_addr  (victim_addr),
    .victim_data  (victim_data),
    .fill_addr    (fill_addr),
    .busy         (busy),
    .fill_valid   (fill_valid),
    .fill_data    (fill_data),
    .err          (err),
    .mem          (bus)
  );

  always #5 clock = ~clock;

  // Memory model: response in the (delay+1)-th cycle of ren/wen; write commits on done.
  logic [BW-1:0] arr [0:1023];
  int            rd_k = 3;
  int            wr_j = 3;
  bit            never = 1'b0;
  int            rcnt = 0;
  int            wcnt = 0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [BW-1:0] pre_data = '0;

  assign bus.mem_ready = bus.mem_ren && !never && (rcnt == rd_k);
  assign bus.mem_done  = bus.mem_wen && !never && (wcnt == wr_j);
  assign bus.mem_dout  = arr[bus.mem_block_address];

  always @(posedge clock) begin
    rcnt <= bus.mem_ren ? rcnt + 1 : 0;
    wcnt <= bus.mem_wen ? wcnt + 1 : 0;
    if (bus.mem_wen && bus.mem_done) arr[bus.mem_block_address] <= bus.mem_din;
    if (pre_we) arr[pre_addr] <= pre_data;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] d);
    @(negedge clock);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clock);
    pre_we   = 1'b0;
  endtask

  // Presents a request during cycle 0; returns at the negedge of cycle 1.
  task automatic start_miss(input logic dirty, input logic [AW-1:0] va, input logic [BW-1:0] vd,
                            input logic [AW-1:0] fa, input logic hold);
    @(negedge clock);
    victim_dirty = dirty;
    victim_addr  = va;
    victim_data  = vd;
    fill_addr    = fa;
    miss_req     = 1'b1;
    @(negedge clock);
    if (!hold) miss_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, fill_valid, err, bus.mem_ren, bus.mem_wen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {busy, fill_valid, err, bus.mem_ren, bus.mem_wen});
    end
    checks++;
    if (fill_data !== '0 || bus.mem_block_address !== '0 || bus.mem_din !== '0) begin
      errors++;
      $display("FAIL reset_data fill=%h addr=%h din=%h want zero", fill_data,
               bus.mem_block_address, bus.mem_din);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_miss();
    logic fv_prev = 1'b0;
    rd_k = 3;
    start_miss(1'b0, 10'h000, '0, 10'h012, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (bus.mem_ren !== (c <= 4) || bus.mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL clean_ren c=%0d ren=%b wen=%b want ren=%b wen=0", c, bus.mem_ren,
                 bus.mem_wen, (c <= 4));
      end
      checks++;
      if (fill_valid !== (c == 5) || busy !== (c <= 5) || (fill_valid && fv_prev)) begin
        errors++;
        $display("FAIL clean_fv c=%0d fv=%b busy=%b want fv=%b busy=%b", c, fill_valid, busy,
                 (c == 5), (c <= 5));
      end
      if (c <= 4) begin
        checks++;
        if (bus.mem_block_address !== 10'h012) begin
          errors++;
          $display("FAIL clean_addr c=%0d got=%h want=012", c, bus.mem_block_address);
        end
      end
      if (c >= 5) begin
        checks++;
        if (fill_data !== DataBeef) begin
          errors++;
          $display("FAIL clean_data c=%0d got=%h want=%h", c, fill_data, DataBeef);
        end
      end
      fv_prev = fill_valid;
      @(negedge clock);
    end
  endtask

  task automatic test_dirty_miss();
    logic fv_prev = 1'b0;
    rd_k = 3;
    wr_j = 3;
    start_miss(1'b1, 10'h040, DataA5, 10'h041, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      checks++;
      if (bus.mem_wen !== (c <= 4) || bus.mem_ren !== (c >= 6 && c <= 9) ||
          (bus.mem_ren && bus.mem_wen)) begin
        errors++;
        $display("FAIL dirty_rw c=%0d ren=%b wen=%b want ren=%b wen=%b", c, bus.mem_ren,
                 bus.mem_wen, (c >= 6 && c <= 9), (c <= 4));
      end
      if (c <= 4) begin
        checks++;
        if (bus.mem_block_address !== 10'h040 || bus.mem_din !== DataA5) begin
          errors++;
          $display("FAIL dirty_wb c=%0d addr=%h din=%h want 040/%h", c, bus.mem_block_address,
                   bus.mem_din, DataA5);
        end
      end else if (c <= 9) begin
        checks++;
        if (bus.mem_block_address !== 10'h041) begin
          errors++;
          $display("FAIL dirty_raddr c=%0d got=%h want=041", c, bus.mem_block_address);
        end
      end
      checks++;
      if (fill_valid !== (c == 10) || busy !== (c <= 10) || (fill_valid && fv_prev)) begin
        errors++;
        $display("FAIL dirty_fv c=%0d fv=%b busy=%b want fv=%b busy=%b", c, fill_valid, busy,
                 (c == 10), (c <= 10));
      end
      if (c == 10) begin
        checks++;
        if (fill_data !== Data41) begin
          errors++;
          $display("FAIL dirty_data got=%h want=%h", fill_data, Data41);
        end
      end
      fv_prev = fill_valid;
      @(negedge clock);
    end
    checks++;
    if (arr[10'h040] !== DataA5) begin
      errors++;
      $display("FAIL dirty_mem got=%h want=%h", arr[10'h040], DataA5);
    end
  endtask

  task automatic test_back_to_back();
    logic fv_prev = 1'b0;
    rd_k = 3;
    start_miss(1'b0, 10'h000, '0, 10'h012, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) fill_addr = 10'h041;
      checks++;
      if (bus.mem_ren !== ((c <= 4) || (c >= 7 && c <= 10)) || bus.mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ren c=%0d ren=%b wen=%b want ren=%b", c, bus.mem_ren, bus.mem_wen,
                 ((c <= 4) || (c >= 7 && c <= 10)));
      end
      checks++;
      if (fill_valid !== (c == 5 || c == 11) || busy !== (c != 6 && c != 12) ||
          (fill_valid && fv_prev)) begin
        errors++;
        $display("FAIL b2b_fv c=%0d fv=%b busy=%b", c, fill_valid, busy);
      end
      if (c == 5 || c == 11) begin
        checks++;
        if (fill_data !== ((c == 5) ? DataBeef : Data41)) begin
          errors++;
          $display("FAIL b2b_data c=%0d got=%h", c, fill_data);
        end
      end
      if (c == 7) miss_req = 1'b0;
      fv_prev = fill_valid;
      @(negedge clock);
    end
  endtask

  task automatic test_timeout();
    never = 1'b1;
    start_miss(1'b0, 10'h000, '0, 10'h012, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (bus.mem_ren !== (c <= 8) || err !== (c >= 9) || busy !== 1'b1 ||
          fill_valid !== 1'b0 || bus.mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL timeout c=%0d ren=%b err=%b busy=%b fv=%b want ren=%b err=%b busy=1 fv=0",
                 c, bus.mem_ren, err, busy, fill_valid, (c <= 8), (c >= 9));
      end
      @(negedge clock);
    end
    never = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, fill_valid, err, bus.mem_ren, bus.mem_wen} !== 5'b0 || fill_data !== '0) begin
      errors++;
      $display("FAIL timeout_reset ctrl=%b fill=%h want zero",
               {busy, fill_valid, err, bus.mem_ren, bus.mem_wen}, fill_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_wb();
    wr_j = 3;
    start_miss(1'b1, 10'h050, Data5A, 10'h051, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus.mem_wen !== 1'b1 || bus.mem_block_address !== 10'h050) begin
        errors++;
        $display("FAIL midwb_wen c=%0d wen=%b addr=%h want 1/050", c, bus.mem_wen,
                 bus.mem_block_address);
      end
      if (c == 2) reset = 1'b1;
      @(negedge clock);
    end
    checks++;
    if ({busy, fill_valid, err, bus.mem_ren, bus.mem_wen} !== 5'b0 || fill_data !== '0 ||
        bus.mem_block_address !== '0 || bus.mem_din !== '0) begin
      errors++;
      $display("FAIL midwb_reset ctrl=%b fill=%h addr=%h din=%h want zero",
               {busy, fill_valid, err, bus.mem_ren, bus.mem_wen}, fill_data,
               bus.mem_block_address, bus.mem_din);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (arr[10'h050] !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midwb_mem mem=%h busy=%b want 0/0", arr[10'h050], busy);
    end
  endtask

  initial begin
    test_reset();
    preload(10'h012, DataBeef);
    preload(10'h040, '0);
    preload(10'h041, Data41);
    preload(10'h050, '0);
    test_clean_miss();
    test_dirty_miss();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dmem_miss_ctrl.md
Name: dmem_miss_ctrl

Overview:
- Data-cache miss handler sitting directly upstream of the data memory model; it drives that memory's ren/wen/block_address/din and consumes its ready/done/dout.
- On a miss it optionally writes back a dirty victim block, then fetches the requested block and returns it to the cache with a one-cycle valid pulse.
- It enforces the memory's protocol rules: ren and wen are never high together, and both are held low for at least one cycle between two operations.
- It also provides a watchdog timeout on every memory operation.

Parameters:
ADDR_W, 10, block-address width (clog2 of DMEM_SIZE)
BLOCK_W, 128, block width in bits (DBLOCK_SIZE_BITS)
TIMEOUT, 64, max cycles spent in one memory operation before error (>=2)

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high reset
miss_req  in  1  cache requests miss service; sampled only in IDLE
victim_dirty  in  1  victim must be written back; sampled with miss_req
victim_addr  in  ADDR_W  victim block address; sampled with miss_req
victim_data  in  BLOCK_W  victim block data; sampled with miss_req
fill_addr  in  ADDR_W  requested block address; sampled with miss_req
busy  out  1  high whenever state != IDLE
fill_valid  out  1  one-cycle pulse; fill_data valid
fill_data  out  BLOCK_W  fetched block; holds value until next capture
err  out  1  sticky timeout flag
mem_ren  out  1  to memory ren
mem_wen  out  1  to memory wen
mem_block_address  out  ADDR_W  to memory block_address
mem_din  out  BLOCK_W  to memory din
mem_ready  in  1  memory read-complete flag
mem_done  in  1  memory write-complete flag
mem_dout  in  BLOCK_W  memory read data; valid while mem_ready=1 and mem_ren=1

Behaviour:
- Reset (synchronous): state=IDLE. All outputs are 0, including fill_data and err. The latched request registers and the timeout counter are cleared. If reset is asserted mid-operation, mem_ren/mem_wen are 0 from the next cycle.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- States: IDLE, WB, GAP, FILL, RESP, ERR.
- IDLE: on miss_req=1, latch victim_addr, victim_data, fill_addr and victim_dirty. Next state is WB if victim_dirty, else FILL.
- WB: mem_wen=1, mem_ren=0, mem_block_address=victim_addr, mem_din=latched victim_data (stable for the whole state). Leave on the first sampled mem_done=1 -> GAP.
- GAP: exactly one cycle with mem_ren=mem_wen=0; mem_block_address=fill_addr. Then -> FILL.
- FILL: mem_ren=1, mem_wen=0, mem_block_address=fill_addr. On the first sampled mem_ready=1, register fill_data<=mem_dout in that same cycle (mem_ren is still high) -> RESP.
- RESP: fill_valid=1 for one cycle with mem_ren=mem_wen=0, then -> IDLE. A miss_req is not accepted in RESP.
- Latency, with miss_req accepted at cycle 0, memory write response at cycle 1+j and read response at 1+k (or 3+j+k for dirty misses):
  - Clean miss: mem_ren rises at cycle 1, fill_valid at cycle 2+k, busy falls at cycle 3+k.
  - Dirty miss: mem_wen at 1, GAP at 2+j, mem_ren at 3+j, fill_valid at 4+j+k.
- Watchdog: the counter clears on entry to WB or FILL and increments every cycle spent in that state.
  - If no response has arrived by the TIMEOUT-th cycle in the state, enter ERR on the next cycle.
  - ERR: err=1, busy=1, mem_ren=mem_wen=0, fill_valid never pulses. Exit only via reset.
- Stray mem_ready/mem_done: ignored outside FILL/WB. mem_ready seen in WB and mem_done seen in FILL are ignored.
- Invariants: mem_ren&mem_wen is never 1. Between any write-back and the following read there is at least one cycle with both low. IDLE always drives both low.
- fill_data is not cleared on IDLE; it only changes on capture or reset.

Test Plan:
- Clean miss: fill_addr=0x012, memory read delay k=3 returns 0xDEAD...BEEF -> mem_ren high cycles 1-4, fill_valid=1 at cycle 5 with fill_data=0xDEAD...BEEF, busy=0 at cycle 6.
- Dirty miss: victim_addr=0x040, victim_data=0xA5..A5, fill_addr=0x041, j=k=3 ->
  - mem_wen high cycles 1-4 with mem_din=0xA5..A5 and addr 0x040;
  - cycle 5 both low;
  - mem_ren cycles 6-9 with addr 0x041;
  - fill_valid at cycle 10;
  - memory model shows 0x040 written.
- Back-to-back: second miss_req held high from cycle 0 -> accepted only in the cycle after busy falls. No overlap of ren/wen, and at least one idle memory cycle between the two reads.
- Timeout: TIMEOUT=8, clean miss, memory never asserts mem_ready -> mem_ren high cycles 1-8, err=1 and mem_ren=0 from cycle 9, busy stays 1, fill_valid never pulses. Reset then returns all outputs to 0.
- Reset mid-WB: assert reset at cycle 2 of a dirty miss -> next cycle state=IDLE, all outputs 0, no memory write committed.
- Protocol checker (all tests): assert mem_ren&mem_wen==0 every cycle, and assert fill_valid is never high for two consecutive cycles.
